adc_spi_reader: RTL and testbench

//  Parametrised reader for MCP3201-class serial ADCs. Generates cs_n/sclk from the system clock and

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_sclk_gen.sv | 45 ++++
 rtl/adc_spi_reader.sv | 154 +++++++++++++++
 tb/tb_adc_spi_reader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC reader: FSM state encoding and
// frame-length / counter-width helpers.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } adc_state_e;

    function automatic int total_bits(input int lead_bits, input int data_bits);
        return lead_bits + data_bits;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV cycles while enabled and the
// phase restarts from zero whenever the enable is low.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rise_en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int               DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_comb begin
        tick      = en && (div_cnt == DIV_LAST);
        rise_tick = tick && !sclk;
        fall_tick = tick && sclk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            // With rise_en low the half-period boundary still ticks but sclk stays low.
            sclk    <= sclk ? 1'b0 : rise_en;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// Reader for MCP3201-class serial ADCs: drives cs_n/sclk, captures NUM_CH
// MISO lines in parallel and hands results over a valid/ready interface.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int DATA_BITS = 12,
    parameter int LEAD_BITS = 3,
    parameter int NUM_CH    = 1,
    parameter int CLK_DIV   = 4,
    parameter int CS_IDLE   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        continuous,
    input  logic [NUM_CH-1:0]           miso,
    output logic                        cs_n,
    output logic                        sclk,
    output logic [NUM_CH*DATA_BITS-1:0] data_out,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        busy,
    output logic                        overrun
);

    localparam int TOTAL = total_bits(LEAD_BITS, DATA_BITS);
    localparam int BC_W  = cnt_width(TOTAL);
    localparam int HC_W  = cnt_width(2 * CS_IDLE);

    localparam logic [BC_W-1:0] BIT_LEAD  = BC_W'(LEAD_BITS);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(TOTAL - 1);
    localparam logic [BC_W-1:0] BIT_DONE  = BC_W'(TOTAL);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(2 * CS_IDLE - 1);

    adc_state_e                  state;
    logic [BC_W-1:0]             bit_cnt;
    logic [HC_W-1:0]             hold_cnt;
    logic                        gen_en;
    logic                        rise_en;
    logic                        rise_tick;
    logic                        fall_tick;
    logic                        sample;
    logic                        frame_done;
    logic                        accept;
    logic [NUM_CH*DATA_BITS-1:0] frame_word;

    always_comb begin
        gen_en     = (state != IDLE);
        rise_en    = (state == SETUP) || ((state == SHIFT) && (bit_cnt != BIT_DONE));
        sample     = (state == SHIFT) && fall_tick;
        frame_done = sample && (bit_cnt == BIT_LAST);
        accept     = data_valid && data_ready;
    end

    adc_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (gen_en),
        .rise_en  (rise_en),
        .sclk     (sclk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    // The last data bit is taken straight from miso so the result lands on the final sclk fall.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_BITS-1:0] sh;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh <= '0;
            end else if (sample && (bit_cnt >= BIT_LEAD)) begin
                sh <= {sh[DATA_BITS-2:0], miso[i]};
            end
        end

        assign frame_word[i*DATA_BITS +: DATA_BITS] = {sh[DATA_BITS-2:0], miso[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        state   <= SETUP;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (rise_tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_tick) begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            cs_n <= 1'b1;
                        end
                    end
                    // The trailing sclk low phase runs out here, so a frame spans TOTAL full periods.
                    if (rise_tick && (bit_cnt == BIT_DONE)) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (rise_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            bit_cnt  <= '0;
                            if (continuous) begin
                                state <= SETUP;
                                cs_n  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HC_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            data_out   <= frame_word;
            data_valid <= 1'b1;
            overrun    <= !accept && (overrun || data_valid);
        end else if (accept) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: three instances (defaults, two channels,
// CLK_DIV=1) each fed by a behavioural ADC that presents bit k during sclk high phase k.
module tb_adc_spi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   n, m, lowcnt, rises, first_hi, vat;
    logic prev;

    // Instance A: default parameters
    logic        rst_a = 1'b0, start_a = 1'b0, cont_a = 1'b0, ready_a = 1'b0;
    logic [0:0]  miso_a = '0;
    logic        cs_a, sclk_a, valid_a, busy_a, ovr_a;
    logic [11:0] dout_a;
    logic [14:0] pat_a [16];
    logic [14:0] cur_a = '0;
    int          fr_a = 0, ix_a = 0;

    adc_spi_reader dut_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .continuous(cont_a), .miso(miso_a),
        .cs_n(cs_a), .sclk(sclk_a), .data_out(dout_a), .data_valid(valid_a),
        .data_ready(ready_a), .busy(busy_a), .overrun(ovr_a)
    );

    always @(negedge cs_a or posedge sclk_a) begin
        if (sclk_a) begin
            if (ix_a < 15) miso_a[0] = cur_a[14 - ix_a];
            ix_a++;
        end else if (!cs_a) begin
            cur_a = pat_a[fr_a % 16];
            fr_a++;
            ix_a = 0;
        end
    end

    // Instance B: two channels
    logic        rst_b = 1'b0, start_b = 1'b0, cont_b = 1'b0, ready_b = 1'b1;
    logic [1:0]  miso_b = '0;
    logic        cs_b, sclk_b, valid_b, busy_b, ovr_b;
    logic [23:0] dout_b;
    logic [14:0] pat_b0 = '0, pat_b1 = '0;
    int          ix_b = 0;

    adc_spi_reader #(.NUM_CH(2)) dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .continuous(cont_b), .miso(miso_b),
        .cs_n(cs_b), .sclk(sclk_b), .data_out(dout_b), .data_valid(valid_b),
        .data_ready(ready_b), .busy(busy_b), .overrun(ovr_b)
    );

    always @(negedge cs_b or posedge sclk_b) begin
        if (sclk_b) begin
            if (ix_b < 15) miso_b = {pat_b1[14 - ix_b], pat_b0[14 - ix_b]};
            ix_b++;
        end else if (!cs_b) begin
            ix_b = 0;
        end
    end

    // Instance C: fastest divider
    logic        rst_c = 1'b0, start_c = 1'b0, cont_c = 1'b0, ready_c = 1'b0;
    logic [0:0]  miso_c = '0;
    logic        cs_c, sclk_c, valid_c, busy_c, ovr_c;
    logic [11:0] dout_c;
    logic [14:0] pat_c = '0;
    int          ix_c = 0;

    adc_spi_reader #(.CLK_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_c), .start(start_c), .continuous(cont_c), .miso(miso_c),
        .cs_n(cs_c), .sclk(sclk_c), .data_out(dout_c), .data_valid(valid_c),
        .data_ready(ready_c), .busy(busy_c), .overrun(ovr_c)
    );

    always @(negedge cs_c or posedge sclk_c) begin
        if (sclk_c) begin
            if (ix_c < 15) miso_c[0] = pat_c[14 - ix_c];
            ix_c++;
        end else if (!cs_c) begin
            ix_c = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_cs_n", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovr", ovr_a, 0);
        chk("rst_b_dout", dout_b, 0);
        chk("rst_c_cs_n", cs_c, 1);
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        step();
        step();

        // 1: single shot, lead 111, data A5C
        pat_a[fr_a] = {3'b111, 12'hA5C};
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t1_cs_low", cs_a, 0);
        chk("t1_busy", busy_a, 1);
        n = 1; lowcnt = !cs_a; rises = 0; first_hi = 0; vat = 0; prev = sclk_a;
        while (busy_a && n < 400) begin
            step();
            n++;
            if (!cs_a) lowcnt++;
            if (sclk_a && !prev) begin
                rises++;
                if (first_hi == 0) first_hi = n;
            end
            prev = sclk_a;
            if (valid_a && vat == 0) vat = n;
        end
        chk("t1_latency", vat, 121);
        chk("t1_cs_low_cycles", lowcnt, 120);
        chk("t1_sclk_pulses", rises, 15);
        chk("t1_first_sclk_high", first_hi, 5);
        chk("t1_busy_end", n, 141);
        chk("t1_dout", dout_a, 12'hA5C);
        chk("t1_valid_held", valid_a, 1);
        chk("t1_ovr", ovr_a, 0);
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        chk("t1_valid_clear", valid_a, 0);

        // 3: continuous, ready low, two frames -> overrun
        pat_a[fr_a]     = {3'b111, 12'h123};
        pat_a[fr_a + 1] = {3'b111, 12'h456};
        cont_a = 1'b1;
        step();
        n = 1;
        while (!valid_a && n < 400) begin step(); n++; end
        chk("t3_latency", n, 121);
        chk("t3_dout1", dout_a, 12'h123);
        chk("t3_ovr1", ovr_a, 0);
        m = 0;
        while (dout_a == 12'h123 && m < 400) begin step(); m++; end
        chk("t3_period", m, 140);
        chk("t3_dout2", dout_a, 12'h456);
        chk("t3_valid2", valid_a, 1);
        chk("t3_ovr2", ovr_a, 1);
        cont_a  = 1'b0;
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        chk("t3_valid_clear", valid_a, 0);
        chk("t3_ovr_clear", ovr_a, 0);
        n = 0;
        while (busy_a && n < 400) begin step(); n++; end
        chk("t3_busy_end", n, 19);
        m = 0;
        repeat (150) begin
            step();
            if (valid_a || !cs_a || busy_a) m++;
        end
        chk("t3_stays_idle", m, 0);

        // 4: ready in completion cycle of frame 2, continuous dropped mid frame 3
        pat_a[fr_a]     = {3'b111, 12'h0F0};
        pat_a[fr_a + 1] = {3'b111, 12'h70E};
        pat_a[fr_a + 2] = {3'b111, 12'h2B1};
        cont_a = 1'b1;
        step();
        n = 1;
        while (!valid_a && n < 400) begin step(); n++; end
        chk("t4_latency", n, 121);
        chk("t4_dout1", dout_a, 12'h0F0);
        repeat (139) step();
        chk("t4_dout_before", dout_a, 12'h0F0);
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        chk("t4_dout2", dout_a, 12'h70E);
        chk("t4_valid2", valid_a, 1);
        chk("t4_ovr2", ovr_a, 0);
        repeat (59) step();
        cont_a = 1'b0;
        m = 0;
        while (dout_a == 12'h70E && m < 400) begin step(); m++; end
        chk("t4_frame3_time", m, 81);
        chk("t4_dout3", dout_a, 12'h2B1);
        chk("t4_ovr3", ovr_a, 1);
        n = 0;
        while (busy_a && n < 400) begin step(); n++; end
        chk("t4_hold_then_idle", n, 20);
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        chk("t4_valid_clear", valid_a, 0);
        chk("t4_ovr_clear", ovr_a, 0);

        // 5: reset at T0+50, then a fresh frame
        pat_a[fr_a]     = {3'b111, 12'hABC};
        pat_a[fr_a + 1] = {3'b111, 12'h3C6};
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (49) step();
        chk("t5_pre_cs", cs_a, 0);
        rst_a = 1'b0;
        #1;
        chk("t5_rst_cs", cs_a, 1);
        chk("t5_rst_sclk", sclk_a, 0);
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_dout", dout_a, 0);
        repeat (3) step();
        rst_a = 1'b1;
        m = 0;
        repeat (150) begin
            step();
            if (valid_a || !cs_a) m++;
        end
        chk("t5_no_frame", m, 0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 1;
        while (!valid_a && n < 400) begin step(); n++; end
        chk("t5_latency", n, 121);
        chk("t5_dout", dout_a, 12'h3C6);

        // 2: two channels, ready held high
        pat_b0 = {3'b111, 12'h001};
        pat_b1 = {3'b000, 12'hFFF};
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        n = 1;
        while (!valid_b && n < 400) begin step(); n++; end
        chk("t2_latency", n, 121);
        chk("t2_dout", dout_b, 24'hFFF001);
        step();
        chk("t2_valid_one_cycle", valid_b, 0);

        // 6: CLK_DIV=1, start re-pulsed while busy
        pat_c = {3'b111, 12'h5A3};
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        chk("t6_sclk_t1", sclk_c, 0);
        step();
        chk("t6_sclk_t2", sclk_c, 1);
        step();
        chk("t6_sclk_t3", sclk_c, 0);
        step();
        chk("t6_sclk_t4", sclk_c, 1);
        repeat (6) step();
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        n = 11;
        while (!valid_c && n < 200) begin step(); n++; end
        chk("t6_latency", n, 31);
        chk("t6_dout", dout_c, 12'h5A3);
        m = 0;
        while (busy_c && m < 100) begin step(); m++; end
        chk("t6_busy_end", m, 5);
        m = 0;
        repeat (60) begin
            step();
            if (busy_c || !cs_c) m++;
        end
        chk("t6_start_not_queued", m, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
